// File: rtl/lib_decmps_to_pow2_seq_if.sv
// Handshake/data bundle for lib_decmps_to_pow2_seq: vector input side and
// streamed one-hot beat output side.
interface lib_decmps_to_pow2_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic                 vld_i;
  logic [WIDTH-1:0]     vect;
  logic                 rdy_o;
  logic                 vld_o;
  logic                 rdy_i;
  logic [LANES-1:0]     lane_vld;
  logic [WIDTH-1:0]     onehot   [LANES-1:0];
  logic [IDX_W-1:0]     idx      [LANES-1:0];
  logic                 last;
  logic [IDX_W:0]       beat_cnt;

  // Block side: consumes vectors, produces beats.
  modport slave (
    input  vld_i, vect, rdy_i,
    output rdy_o, vld_o, lane_vld, onehot, idx, last, beat_cnt
  );

  // Environment side: produces vectors, consumes beats.
  modport master (
    output vld_i, vect, rdy_i,
    input  rdy_o, vld_o, lane_vld, onehot, idx, last, beat_cnt
  );
endinterface

// File: rtl/lib_decmps_to_pow2_seq.sv
// Streams the set bits of a WIDTH-bit vector as one-hot vectors, up to LANES
// per beat, in LSB-first (LSB_MSB=0) or MSB-first (LSB_MSB=1) order.
module lib_decmps_to_pow2_seq #(
  parameter bit          LSB_MSB = 1'b0,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LANES   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  lib_decmps_to_pow2_seq_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  res_q;
  logic [WIDTH-1:0]  res_d;
  logic [IDX_W:0]    beat_cnt_q;

  logic [WIDTH-1:0]  oh_c   [LANES-1:0];
  logic [IDX_W-1:0]  idx_c  [LANES-1:0];
  logic [LANES-1:0]  lvld_c;

  logic busy;
  logic last_c;
  logic out_acc;
  logic in_acc;
  logic rdy_c;

  // Cascade of find-first-set stages; each stage sees only bits not claimed
  // by earlier lanes, and whatever survives all stages is the next residue.
  always_comb begin
    logic [WIDTH-1:0] avail;
    logic [IDX_W-1:0] pos;
    logic             found;
    avail = res_q;
    pos   = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      found    = 1'b0;
      oh_c[k]  = '0;
      idx_c[k] = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        pos = LSB_MSB ? IDX_W'(WIDTH - 1 - i) : IDX_W'(i);
        if (!found && avail[pos]) begin
          found       = 1'b1;
          oh_c[k][pos] = 1'b1;
          idx_c[k]    = pos;
        end
      end
      lvld_c[k] = found;
      avail     = avail & ~oh_c[k];
    end
    res_d = avail;
  end

  // Handshake terms; a beat can retire and a new vector load in one cycle.
  always_comb begin
    busy    = (state_q == BUSY);
    last_c  = busy && (res_d == '0);
    out_acc = busy && bus.rdy_i;
    rdy_c   = !busy || (out_acc && last_c);
    in_acc  = bus.vld_i && rdy_c;
  end

  // State, residue and beat counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      res_q      <= '0;
      beat_cnt_q <= '0;
    end else if (in_acc) begin
      state_q    <= BUSY;
      res_q      <= bus.vect;
      beat_cnt_q <= '0;
    end else if (out_acc) begin
      res_q      <= res_d;
      beat_cnt_q <= beat_cnt_q + 1'b1;
      if (last_c) begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.rdy_o    = rdy_c;
  assign bus.vld_o    = busy;
  assign bus.lane_vld = lvld_c;
  assign bus.onehot   = oh_c;
  assign bus.idx      = idx_c;
  assign bus.last     = last_c;
  assign bus.beat_cnt = beat_cnt_q;

endmodule
